// File: rtl/pe_dmem_mp_if.sv
// pe_dmem_mp_if -- bus bundle for the per-PE multi-port data memory.
//   Write sources : ld/sh/tx stream writes (we + din) and ALU write-back (wb_we/wb_din)
//   Instruction   : inst_v, inst = {src[NRP-1], ..., src[0], dst}, each ADDR_W wide
//   Read results  : rd_dout (source k in slice k), rd_v
//   Streaming read: rs_en in, rs_dout/rs_v out
//   Status        : wr_err (sticky write-collision flag)
// Modports: master = the PE side driving requests, slave = the memory.
interface pe_dmem_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int NRP    = 2
);
   logic                       ld_we;
   logic [DATA_W-1:0]          ld_din;
   logic                       sh_we;
   logic [DATA_W-1:0]          sh_din;
   logic                       tx_we;
   logic [DATA_W-1:0]          tx_din;
   logic                       wb_we;
   logic [DATA_W-1:0]          wb_din;
   logic                       inst_v;
   logic [(NRP+1)*ADDR_W-1:0]  inst;
   logic [NRP*DATA_W-1:0]      rd_dout;
   logic                       rd_v;
   logic                       rs_en;
   logic [DATA_W-1:0]          rs_dout;
   logic                       rs_v;
   logic                       wr_err;

   modport master (
      output ld_we, ld_din, sh_we, sh_din, tx_we, tx_din, wb_we, wb_din,
             inst_v, inst, rs_en,
      input  rd_dout, rd_v, rs_dout, rs_v, wr_err
   );

   modport slave (
      input  ld_we, ld_din, sh_we, sh_din, tx_we, tx_din, wb_we, wb_din,
             inst_v, inst, rs_en,
      output rd_dout, rd_v, rs_dout, rs_v, wr_err
   );
endinterface

// File: rtl/pe_dmem_mp.sv
// pe_dmem_mp -- multi-port data memory for one PE.
//   Ports: clk, rst (synchronous, active-high), bus (pe_dmem_mp_if.slave).
//   Four write sources are arbitrated ld > sh > tx > wb onto one registered write
//   port; the write lands in NRP+1 replicated RAM copies one edge later. Copies
//   0..NRP-1 serve the instruction read ports, copy NRP the streaming read port.
//   Reads sample the RAM on the request edge and pass through an output register.
// Optional feature: define DMEM_BYPASS_EN to forward a same-edge write to a read
//   of the same address (otherwise read-first returns the pre-write contents).
module pe_dmem_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int NRP      = 2,
   parameter int WB_DELAY = 5,
   parameter int LD_BASE  = 0,
   parameter int SH_BASE  = 32,
   parameter int TX_BASE  = 160
) (
   input  logic          clk,
   input  logic          rst,
   pe_dmem_mp_if.slave   bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   addr_t ld_ptr_q, ld_ptr_d, sh_ptr_q, sh_ptr_d, tx_ptr_q, tx_ptr_d;
   addr_t rs_ptr_q, rs_ptr_d;
   addr_t wb_dl_q [WB_DELAY];
   addr_t wb_dl_d [WB_DELAY];
   addr_t wa_q, wa_d;
   data_t wd_q, wd_d;
   logic  wv_q, wv_d;
   logic  wr_err_q, wr_err_d;
   logic  rd_p1_q, rd_p1_d, rd_v_q, rd_v_d;
   logic  rs_p1_q, rs_p1_d, rs_v_q, rs_v_d;
   logic [NRP*DATA_W-1:0] rd_dout_q, rd_dout_d;
   data_t rs_dout_q, rs_dout_d;

   addr_t ra [NRP+1];
   logic [NRP:0] re;
   logic [(NRP+1)*DATA_W-1:0] ram_rd;
   logic any_req, collide;

   // Write arbitration, stream pointers and write-back delay line
   always_comb begin
      ld_ptr_d = ld_ptr_q;
      sh_ptr_d = sh_ptr_q;
      tx_ptr_d = tx_ptr_q;
      wa_d     = wa_q;
      wd_d     = wd_q;
      wv_d     = 1'b0;
      any_req  = bus.ld_we | bus.sh_we | bus.tx_we | bus.wb_we;
      collide  = (bus.ld_we & (bus.sh_we | bus.tx_we | bus.wb_we)) |
                 (bus.sh_we & (bus.tx_we | bus.wb_we)) |
                 (bus.tx_we & bus.wb_we);
      wr_err_d = wr_err_q | collide;
      if (bus.ld_we) begin
         wa_d = ld_ptr_q; wd_d = bus.ld_din; wv_d = 1'b1;
         ld_ptr_d = ld_ptr_q + ADDR_W'(1);
      end else if (bus.sh_we) begin
         wa_d = sh_ptr_q; wd_d = bus.sh_din; wv_d = 1'b1;
         sh_ptr_d = sh_ptr_q + ADDR_W'(1);
      end else if (bus.tx_we) begin
         wa_d = tx_ptr_q; wd_d = bus.tx_din; wv_d = 1'b1;
         tx_ptr_d = tx_ptr_q + ADDR_W'(1);
      end else if (bus.wb_we) begin
         wa_d = wb_dl_q[WB_DELAY-1]; wd_d = bus.wb_din; wv_d = 1'b1;
      end
      // An idle cycle marks a stream frame end
      if (!any_req) begin
         ld_ptr_d = ADDR_W'(LD_BASE);
         sh_ptr_d = ADDR_W'(SH_BASE);
         tx_ptr_d = ADDR_W'(TX_BASE);
      end
      wb_dl_d[0] = bus.inst_v ? bus.inst[ADDR_W-1:0] : '0;
      for (int unsigned i = 1; i < WB_DELAY; i++) wb_dl_d[i] = wb_dl_q[i-1];
      rs_ptr_d = bus.rs_en ? rs_ptr_q + ADDR_W'(1) : ADDR_W'(SH_BASE);
   end

   // Read addresses/enables per RAM copy
   always_comb begin
      for (int unsigned k = 0; k < NRP; k++) ra[k] = bus.inst[(k+1)*ADDR_W +: ADDR_W];
      ra[NRP] = rs_ptr_q;
   end
   assign re = {bus.rs_en, {NRP{bus.inst_v}}};

   // Output registers load only behind a valid RAM read, so they hold otherwise
   always_comb begin
      rd_p1_d   = bus.inst_v;
      rd_v_d    = rd_p1_q;
      rd_dout_d = rd_p1_q ? ram_rd[NRP*DATA_W-1:0] : rd_dout_q;
      rs_p1_d   = bus.rs_en;
      rs_v_d    = rs_p1_q;
      rs_dout_d = rs_p1_q ? ram_rd[NRP*DATA_W +: DATA_W] : rs_dout_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_ptr_q  <= ADDR_W'(LD_BASE);
         sh_ptr_q  <= ADDR_W'(SH_BASE);
         tx_ptr_q  <= ADDR_W'(TX_BASE);
         rs_ptr_q  <= ADDR_W'(SH_BASE);
         for (int unsigned i = 0; i < WB_DELAY; i++) wb_dl_q[i] <= '0;
         wa_q      <= '0;
         wd_q      <= '0;
         wv_q      <= 1'b0;
         wr_err_q  <= 1'b0;
         rd_p1_q   <= 1'b0;
         rd_v_q    <= 1'b0;
         rd_dout_q <= '0;
         rs_p1_q   <= 1'b0;
         rs_v_q    <= 1'b0;
         rs_dout_q <= '0;
      end else begin
         ld_ptr_q  <= ld_ptr_d;
         sh_ptr_q  <= sh_ptr_d;
         tx_ptr_q  <= tx_ptr_d;
         rs_ptr_q  <= rs_ptr_d;
         for (int unsigned i = 0; i < WB_DELAY; i++) wb_dl_q[i] <= wb_dl_d[i];
         wa_q      <= wa_d;
         wd_q      <= wd_d;
         wv_q      <= wv_d;
         wr_err_q  <= wr_err_d;
         rd_p1_q   <= rd_p1_d;
         rd_v_q    <= rd_v_d;
         rd_dout_q <= rd_dout_d;
         rs_p1_q   <= rs_p1_d;
         rs_v_q    <= rs_v_d;
         rs_dout_q <= rs_dout_d;
      end
   end

   // Replicated simple-dual-port RAMs; rst suppresses a write still in the stage
   for (genvar k = 0; k <= NRP; k++) begin : g_copy
      data_t mem [DEPTH];
      data_t rd_word;
      always_ff @(posedge clk) begin
         if (wv_q && !rst) mem[wa_q] <= wd_q;
         if (re[k]) begin
`ifdef DMEM_BYPASS_EN
            if (wv_q && !rst && wa_q == ra[k]) rd_word <= wd_q;
            else                               rd_word <= mem[ra[k]];
`else
            rd_word <= mem[ra[k]];
`endif
         end
      end
      assign ram_rd[k*DATA_W +: DATA_W] = rd_word;
   end

   assign bus.rd_dout = rd_dout_q;
   assign bus.rd_v    = rd_v_q;
   assign bus.rs_dout = rs_dout_q;
   assign bus.rs_v    = rs_v_q;
   assign bus.wr_err  = wr_err_q;
endmodule

// File: tb/tb_pe_dmem_mp.sv
// tb_pe_dmem_mp -- directed self-checking bench for pe_dmem_mp (default parameters).
module tb_pe_dmem_mp;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;

   pe_dmem_mp_if #(.DATA_W(32), .ADDR_W(8), .NRP(2)) bus ();

   pe_dmem_mp #(
      .DATA_W(32), .ADDR_W(8), .NRP(2), .WB_DELAY(5),
      .LD_BASE(0), .SH_BASE(32), .TX_BASE(160)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Issue one instruction read and check both slices two cycles later
   task automatic rd_chk(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [31:0] e0, input logic [31:0] e1);
      bus.inst   = {s1, s0, 8'd0};
      bus.inst_v = 1'b1;
      tick();
      bus.inst_v = 1'b0;
      chk({tag, "_v_early"}, {63'd0, bus.rd_v}, 64'd0);
      tick();
      chk({tag, "_v"}, {63'd0, bus.rd_v}, 64'd1);
      chk({tag, "_data"}, bus.rd_dout, {e1, e0});
      tick();
      chk({tag, "_v_pulse"}, {63'd0, bus.rd_v}, 64'd0);
   endtask

   logic [31:0] byp_exp;

   initial begin
      bus.ld_we = 0; bus.ld_din = '0; bus.sh_we = 0; bus.sh_din = '0;
      bus.tx_we = 0; bus.tx_din = '0; bus.wb_we = 0; bus.wb_din = '0;
      bus.inst_v = 0; bus.inst = '0; bus.rs_en = 0;
      rst = 1'b1;
      idle(2);
      chk("rst_rd_dout", bus.rd_dout, 64'd0);
      chk("rst_rd_v", {63'd0, bus.rd_v}, 64'd0);
      chk("rst_rs_dout", {32'd0, bus.rs_dout}, 64'd0);
      chk("rst_rs_v", {63'd0, bus.rs_v}, 64'd0);
      chk("rst_wr_err", {63'd0, bus.wr_err}, 64'd0);
      rst = 1'b0;
      idle(1);

      // Load stream A0..A3 into 0..3
      for (int i = 0; i < 4; i++) begin
         bus.ld_we = 1'b1; bus.ld_din = 32'hA0 + 32'(i);
         tick();
      end
      bus.ld_we = 1'b0;
      idle(1);
      rd_chk("ld_rd", 8'd2, 8'd3, 32'hA2, 32'hA3);
      chk("no_err_yet", {63'd0, bus.wr_err}, 64'd0);

      // sh vs tx collision: sh wins, tx dropped, tx pointer stays at base
      bus.sh_we = 1'b1; bus.sh_din = 32'h5A5A;
      bus.tx_we = 1'b1; bus.tx_din = 32'hDEAD0001;
      tick();
      bus.sh_we = 1'b0;
      chk("coll_err", {63'd0, bus.wr_err}, 64'd1);
      bus.tx_din = 32'h7777;
      tick();
      bus.tx_we = 1'b0;
      idle(2);
      rd_chk("coll_rd", 8'd32, 8'd160, 32'h5A5A, 32'h7777);

      // Write-back via delay line: dst 64 at cycle 0, wb_we at cycle WB_DELAY
      bus.inst = {8'd0, 8'd0, 8'd64};
      bus.inst_v = 1'b1;
      tick();
      bus.inst_v = 1'b0;
      idle(4);
      bus.wb_we = 1'b1; bus.wb_din = 32'h1234;
      tick();
      bus.wb_we = 1'b0;
      idle(2);
      rd_chk("wb_rd", 8'd64, 8'd0, 32'h1234, 32'h100 - 32'h100 + 32'hA0);

      // Shift stream B0..B2 into 32..34, then stream them back
      for (int i = 0; i < 3; i++) begin
         bus.sh_we = 1'b1; bus.sh_din = 32'hB0 + 32'(i);
         tick();
      end
      bus.sh_we = 1'b0;
      idle(2);
      bus.rs_en = 1'b1;
      tick();
      chk("rs_v_early", {63'd0, bus.rs_v}, 64'd0);
      tick();
      chk("rs_v0", {63'd0, bus.rs_v}, 64'd1);
      chk("rs_d0", {32'd0, bus.rs_dout}, 64'hB0);
      tick();
      chk("rs_d1", {32'd0, bus.rs_dout}, 64'hB1);
      bus.rs_en = 1'b0;
      tick();
      chk("rs_d2", {32'd0, bus.rs_dout}, 64'hB2);
      tick();
      chk("rs_v_end", {63'd0, bus.rs_v}, 64'd0);

      // Same-edge write and stream read of address 32
`ifdef DMEM_BYPASS_EN
      byp_exp = 32'h55;
`else
      byp_exp = 32'hB0;
`endif
      bus.sh_we = 1'b1; bus.sh_din = 32'h55;
      tick();
      bus.sh_we = 1'b0;
      bus.rs_en = 1'b1;
      tick();
      bus.rs_en = 1'b0;
      tick();
      chk("byp_v", {63'd0, bus.rs_v}, 64'd1);
      chk("byp_d", {32'd0, bus.rs_dout}, {32'd0, byp_exp});
      idle(2);
      rd_chk("after_byp", 8'd32, 8'd33, 32'h55, 32'hB1);

      // Load pointer wrap: 257 writes, the last lands at address 0
      for (int i = 0; i < 257; i++) begin
         bus.ld_we = 1'b1; bus.ld_din = 32'(i);
         tick();
      end
      bus.ld_we = 1'b0;
      idle(2);
      rd_chk("wrap_rd", 8'd0, 8'd255, 32'h100, 32'hFF);
      chk("err_sticky", {63'd0, bus.wr_err}, 64'd1);

      // Reset with a pending write and in-flight reads
      bus.ld_we = 1'b1; bus.ld_din = 32'hDEAD;
      bus.inst = {8'd255, 8'd0, 8'd0};
      bus.inst_v = 1'b1;
      bus.rs_en = 1'b1;
      tick();
      bus.ld_we = 1'b0; bus.inst_v = 1'b0; bus.rs_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_rd_v", {63'd0, bus.rd_v}, 64'd0);
      chk("rstmid_rd_dout", bus.rd_dout, 64'd0);
      chk("rstmid_rs_v", {63'd0, bus.rs_v}, 64'd0);
      chk("rstmid_rs_dout", {32'd0, bus.rs_dout}, 64'd0);
      chk("rstmid_wr_err", {63'd0, bus.wr_err}, 64'd0);
      tick();
      chk("rstmid_rd_v2", {63'd0, bus.rd_v}, 64'd0);
      idle(1);
      rd_chk("rstmid_keep", 8'd0, 8'd1, 32'h100, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
